// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : MEM pipeline stage between the EX/MEM and MEM/WB registers.
//            Runs load/store accesses against a multi-cycle data memory over a
//            req/ready handshake. It holds the front of the pipeline stalled
//            until each access completes. It presents the registered load
//            data, the ALU result and the writeback control to MEM/WB.
// Options  : `define DMEM_TIMEOUT_EN adds a BUSY watchdog. An access still
//            waiting after TIMEOUT_CYCLES BUSY cycles is aborted. The stage
//            then returns 32'hDEADBEEF and raises o_bus_err for one cycle.
//            When the macro is undefined, o_bus_err is tied to 0.
// Ports    :
//   clk, rst            clock, synchronous active-high reset
//   i_alu_result        effective address / ALU result from EX/MEM
//   i_write_data        store data from EX/MEM
//   i_rd, i_reg_write   destination register and regfile write enable
//   i_wb_sel            writeback select
//   i_mem_read/write    load / store request from EX/MEM
//   o_read_data         registered load data to MEM/WB
//   o_alu_out, o_rd_out, o_wb_sel_out   combinational passthroughs
//   o_reg_write_out     write enable, gated during stall/misalign/bus error
//   o_stall             freezes PC, IF/ID, ID/EX and EX/MEM
//   o_misalign          load/store with a non word-aligned address
//   o_bus_err           access aborted by the watchdog
//   o_dmem_*            memory request, write flag, word address, store data
//   i_dmem_ready        memory completion, sampled at the rising edge
//   i_dmem_rdata        load data, valid while i_dmem_ready is high
// Revision : 1.0  initial release
// ============================================================================
module mem_access_stage #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  // EX/MEM side
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_write_data,
  input  logic [4:0]        i_rd,
  input  logic              i_reg_write,
  input  logic [1:0]        i_wb_sel,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  // MEM/WB side
  output logic [DATA_W-1:0] o_read_data,
  output logic [DATA_W-1:0] o_alu_out,
  output logic [4:0]        o_rd_out,
  output logic              o_reg_write_out,
  output logic [1:0]        o_wb_sel_out,
  // Hazard / status
  output logic              o_stall,
  output logic              o_misalign,
  output logic              o_bus_err,
  // Data memory bus
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [DATA_W-1:0] o_dmem_wdata,
  input  logic              i_dmem_ready,
  input  logic [DATA_W-1:0] i_dmem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] C_ERR_DATA = DATA_W'(32'hDEADBEEF);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_rdata_q;

  logic                w_any_mem;
  logic                w_misalign;
  logic                w_memop;
  logic                w_req;
  logic                w_stall;
  logic                w_capture;   // completion seen this cycle
  logic                w_timeout;   // watchdog expiry this cycle
  logic                w_tmo_hit;   // watchdog at its last BUSY cycle
  logic                w_bus_err;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  assign w_any_mem  = i_mem_read | i_mem_write;
  assign w_misalign = w_any_mem & (i_alu_result[1:0] != 2'b00);
  assign w_memop    = w_any_mem & ~w_misalign;

  // --------------------------------------------------------------------------
  // Optional BUSY watchdog
  // --------------------------------------------------------------------------
`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_bus_err;

  // The counter sits at zero outside BUSY, so it is already clear when BUSY
  // is entered. It holds the number of BUSY cycles already completed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state != ST_BUSY) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // The Nth BUSY cycle is the one with a count of N-1.
  assign w_tmo_hit = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // A timeout always moves the FSM to DONE. This flag is therefore high for
  // exactly the DONE cycle that follows the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_timeout;
    end
  end

  assign w_bus_err = r_bus_err & ~rst;
`else
  assign w_tmo_hit = 1'b0;
  assign w_bus_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Non-memory ops and misaligned ops pass straight through.
        if (w_memop) begin
          w_req   = 1'b1;
          w_stall = 1'b1;
          if (i_dmem_ready) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        // EX/MEM is frozen here, so the bus fields stay stable.
        w_req   = 1'b1;
        w_stall = 1'b1;
        if (i_dmem_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_tmo_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // EX/MEM advances at this edge. Returning to IDLE unconditionally
        // means the completed instruction is never issued a second time.
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Load data register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata_q <= '0;
    end else if (w_timeout) begin
      r_rdata_q <= C_ERR_DATA;
    end else if (w_capture && i_mem_read) begin
      r_rdata_q <= i_dmem_rdata;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_read_data  = r_rdata_q;
  assign o_alu_out    = i_alu_result;
  assign o_rd_out     = i_rd;
  assign o_wb_sel_out = i_wb_sel;
  assign o_misalign   = w_misalign;
  assign o_bus_err    = w_bus_err;

  // Reset masks the handshake immediately, without waiting for the edge.
  assign o_stall      = w_stall & ~rst;
  assign o_dmem_req   = w_req & ~rst;

  // Each stalled cycle becomes a bubble in MEM/WB.
  assign o_reg_write_out = i_reg_write & ~o_stall & ~w_misalign & ~w_bus_err & ~rst;

  assign o_dmem_we    = i_mem_write;
  assign o_dmem_addr  = {i_alu_result[ADDR_W-1:2], 2'b00};
  assign o_dmem_wdata = i_write_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Self-checking bench for mem_access_stage. It runs directed
//            scenarios and then a random stream of operations. Expected values
//            come from an instruction-level model. An aligned memory op with
//            w wait cycles keeps stall high for w+1 cycles, then spends one
//            cycle in completion. Load data lands in the read register. With
//            the watchdog enabled, an access that waits more than
//            TIMEOUT_CYCLES BUSY cycles ends with the error pattern.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_stage;

`ifdef DMEM_TIMEOUT_EN
  localparam int TMO    = 4;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 255;
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [4:0]  rd;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] read_data;
  logic [31:0] alu_out;
  logic [4:0]  rd_out;
  logic        reg_write_out;
  logic [1:0]  wb_sel_out;
  logic        stall;
  logic        misalign;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_rdata;

  mem_access_stage #(
    .DATA_W(32),
    .ADDR_W(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_alu_result   (alu_result),
    .i_write_data   (write_data),
    .i_rd           (rd),
    .i_reg_write    (reg_write),
    .i_wb_sel       (wb_sel),
    .i_mem_read     (mem_read),
    .i_mem_write    (mem_write),
    .o_read_data    (read_data),
    .o_alu_out      (alu_out),
    .o_rd_out       (rd_out),
    .o_reg_write_out(reg_write_out),
    .o_wb_sel_out   (wb_sel_out),
    .o_stall        (stall),
    .o_misalign     (misalign),
    .o_bus_err      (bus_err),
    .o_dmem_req     (dmem_req),
    .o_dmem_we      (dmem_we),
    .o_dmem_addr    (dmem_addr),
    .o_dmem_wdata   (dmem_wdata),
    .i_dmem_ready   (dmem_ready),
    .i_dmem_rdata   (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-length directed run; this only fires if simulation runs away.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Passthrough fields must follow the inputs every cycle.
  task automatic chk_pass(input string tag);
    chk(tag, {alu_out, rd_out, wb_sel_out}, {alu_result, rd, wb_sel});
  endtask

  // Runs one instruction to completion. w is the number of request cycles
  // during which memory holds ready low. mdata is the memory's load answer.
  task automatic run_op(input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] rdi, input logic rw, input logic [1:0] wbs,
                        input logic mr, input logic mw, input int w,
                        input logic [31:0] mdata);
    bit is_mem;
    bit mis;
    bit tmo;
    int busy_n;
    is_mem = mr | mw;
    mis    = is_mem && (alu[1:0] != 2'b00);
    alu_result = alu; write_data = wd; rd = rdi; reg_write = rw;
    wb_sel = wbs; mem_read = mr; mem_write = mw;
    if (!is_mem || mis) begin
      // No access: ready/rdata here are noise that must be ignored.
      dmem_ready = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      @(negedge clk);
      chk("pass_ctl", {stall, dmem_req, reg_write_out, misalign, bus_err},
          {1'b0, 1'b0, rw & ~mis, mis, 1'b0});
      chk("pass_rdata", read_data, exp_rdata);
      chk_pass("pass_fwd");
      next_cycle();
    end else begin
      tmo    = TMO_EN && (w > TMO);
      busy_n = tmo ? TMO : w;
      // Request phase: the first cycle plus busy_n waiting cycles.
      for (int k = 0; k <= busy_n; k++) begin
        dmem_ready = !tmo && (k == w);
        dmem_rdata = (k == w) ? mdata : $urandom;
        @(negedge clk);
        chk("req_ctl", {stall, dmem_req, reg_write_out, misalign, bus_err},
            {1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        chk("req_bus", {dmem_addr, dmem_we, dmem_wdata}, {alu & 32'hFFFF_FFFC, mw, wd});
        chk("req_rdata", read_data, exp_rdata);
        chk_pass("req_fwd");
        next_cycle();
      end
      if (tmo)     exp_rdata = 32'hDEADBEEF;
      else if (mr) exp_rdata = mdata;
      // Completion cycle: memory activity must have no effect.
      dmem_ready = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      @(negedge clk);
      chk("done_ctl", {stall, dmem_req, reg_write_out, misalign, bus_err},
          {1'b0, 1'b0, rw & ~tmo, 1'b0, tmo});
      chk("done_rdata", read_data, exp_rdata);
      next_cycle();
    end
  endtask

  initial begin
    int kind;
    logic [31:0] a;
    rst = 1'b1;
    exp_rdata = 32'h0;
    // Memory op presented under reset: the handshake must stay quiet.
    alu_result = 32'h100; write_data = 32'h0; rd = 5'd1; reg_write = 1'b1;
    wb_sel = 2'b01; mem_read = 1'b1; mem_write = 1'b0;
    dmem_ready = 1'b1; dmem_rdata = 32'h5555_AAAA;
    next_cycle();
    @(negedge clk);
    chk("reset_ctl", {stall, dmem_req, reg_write_out, bus_err}, 4'b0000);
    chk("reset_rdata", read_data, 32'h0);
    next_cycle();
    rst = 1'b0;

    // Zero-wait load.
    run_op(32'h100, 32'h0, 5'd3, 1'b1, 2'b01, 1'b1, 1'b0, 0, 32'hCAFEF00D);
    // Store with three wait cycles; the load register must keep its value.
    run_op(32'h40, 32'h12345678, 5'd4, 1'b0, 2'b00, 1'b0, 1'b1, 3, 32'h0BAD_0BAD);
    // ALU-only stream.
    for (int i = 0; i < 8; i++)
      run_op($urandom, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
             2'($urandom), 1'b0, 1'b0, 0, 32'h0);
    // Misaligned load.
    run_op(32'h102, 32'h0, 5'd7, 1'b1, 2'b01, 1'b1, 1'b0, 0, 32'h1111_2222);

    // Reset in the second BUSY cycle of a load.
    alu_result = 32'h200; mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1;
    dmem_ready = 1'b0; dmem_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("rstbusy_issue", {stall, dmem_req}, 2'b11);
    next_cycle();
    @(negedge clk);
    chk("rstbusy_busy1", {stall, dmem_req}, 2'b11);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("rstbusy_during", {stall, dmem_req, reg_write_out, bus_err}, 4'b0000);
    next_cycle();
    rst = 1'b0; mem_read = 1'b0; dmem_ready = 1'b1;
    exp_rdata = 32'h0;
    @(negedge clk);
    chk("rstbusy_after", {stall, dmem_req, reg_write_out}, 3'b001);
    chk("rstbusy_rdata", read_data, 32'h0);
    next_cycle();

`ifdef DMEM_TIMEOUT_EN
    // Memory never answers: the watchdog must abort the access.
    run_op(32'h80, 32'h0, 5'd9, 1'b1, 2'b01, 1'b1, 1'b0, TMO + 3, 32'h0);
`endif

    // Random mix: non-memory, load, store, misaligned.
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 3));
      a    = $urandom & 32'hFFFF_FFFC;
      if (kind == 3) a[1:0] = 2'($urandom_range(1, 3));
      run_op(a, $urandom, 5'($urandom), 1'($urandom_range(0, 1)), 2'($urandom),
             (kind == 1) || (kind == 3), kind == 2, int'($urandom_range(0, 5)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage. Sits between the EX/MEM register and the MEM/WB register.
- Runs load/store accesses against a multi-cycle data memory through a req/ready handshake.
- Raises a pipeline stall to the hazard unit until each access completes.
- Presents read data, ALU result and writeback control to MEM/WB.

Parameters:
- DATA_W, 32, data width of the data path and memory.
- ADDR_W, 32, address width.
- TIMEOUT_CYCLES, 255, watchdog limit in BUSY. Used only with DMEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- alu_result  in  DATA_W  effective address / ALU result from EX/MEM
- write_data  in  DATA_W  store data from EX/MEM
- rd  in  5  destination register
- reg_write  in  1  regfile write enable
- wb_sel  in  2  writeback select
- mem_read  in  1  load
- mem_write  in  1  store
- read_data  out  DATA_W  registered load data, to MEM/WB
- alu_out  out  DATA_W  alu_result passthrough
- rd_out  out  5  rd passthrough
- reg_write_out  out  1  gated write enable
- wb_sel_out  out  2  wb_sel passthrough
- stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
- misalign  out  1  load/store with alu_result[1:0] != 0
- bus_err  out  1  access aborted by timeout (only with DMEM_TIMEOUT_EN, else tied 0)
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word-aligned address
- dmem_wdata  out  DATA_W  store data
- dmem_ready  in  1  memory completion, sampled at rising edge
- dmem_rdata  in  DATA_W  load data, valid when dmem_ready = 1

Behaviour:
- State machine: IDLE, BUSY, DONE. memop = (mem_read | mem_write) & ~misalign.
- misalign = (mem_read | mem_write) & (alu_result[1:0] != 0), combinational.
- Misaligned op: no request, no stall, remains in IDLE.
- Passthrough: alu_out, rd_out and wb_sel_out follow their inputs combinationally.
- Write enable gating: reg_write_out = reg_write & ~stall & ~misalign & ~bus_err. Each stalled cycle therefore inserts a bubble into MEM/WB.
- IDLE:
  - If memop: dmem_req = 1 and stall = 1.
  - If dmem_ready is also 1 in that cycle: capture rdata_q <= dmem_rdata (loads only) and go to DONE. Otherwise go to BUSY.
  - If not memop: stall = 0, dmem_req = 0, remain in IDLE. Non-memory ops add zero latency.
- BUSY:
  - dmem_req = 1, stall = 1.
  - dmem_addr, dmem_we and dmem_wdata are held stable because EX/MEM is frozen.
  - On dmem_ready: capture data and go to DONE.
- DONE:
  - dmem_req = 0, stall = 0; read_data shows the captured value.
  - EX/MEM advances at this edge. Next state is IDLE unconditionally, so the completed instruction is never re-issued.
- Memory bus signals:
  - dmem_addr = {alu_result[ADDR_W-1:2], 2'b00}.
  - dmem_we = mem_write.
  - dmem_wdata = write_data.
- Latency: the minimum memop occupancy is 2 cycles (1 stall cycle), plus 1 cycle for each cycle dmem_ready stays low.
- Store data: on a store, rdata_q is unchanged.
- read_data = rdata_q at all times.
- Reset:
  - While rst = 1: dmem_req = 0, stall = 0, reg_write_out = 0, bus_err = 0.
  - At a clock edge with rst = 1: state <= IDLE, rdata_q <= 0, timeout counter <= 0.
  - Reset during BUSY abandons the access. Memory must tolerate a dropped req.
- dmem_ready while not requesting (IDLE without memop, or DONE) is ignored.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES with dmem_ready still 0: rdata_q <= 32'hDEADBEEF, bus_err = 1 for the DONE cycle, then DONE as normal.
  - reg_write_out is suppressed in that DONE cycle.
- When undefined:
  - No counter is built and bus_err is constant 0.
  - BUSY waits indefinitely.

Test Plan:
1. Zero-wait load: mem_read = 1, alu_result = 0x100, dmem_ready = 1 in the same cycle, dmem_rdata = 0xCAFEF00D -> stall high 1 cycle, reg_write_out 0 then 1, read_data = 0xCAFEF00D in DONE, dmem_addr = 0x100.
2. 3-wait store: mem_write = 1, addr 0x40, data 0x12345678, dmem_ready low 3 cycles -> stall high 4 cycles, dmem_req stable with we = 1, rdata_q unchanged, then DONE and IDLE.
3. ALU op stream with no memops -> stall never asserts, outputs equal inputs each cycle, dmem_req = 0.
4. Misaligned load, alu_result = 0x102 -> misalign = 1, dmem_req = 0, stall = 0, reg_write_out = 0.
5. rst asserted in the 2nd BUSY cycle -> next cycle state IDLE, dmem_req = 0, stall = 0, read_data = 0.
6. With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, dmem_ready held 0 -> after 4 BUSY cycles: DONE, bus_err = 1, read_data = 0xDEADBEEF, reg_write_out = 0.
